// File: rtl/control_unit.sv
// control_unit -- multi-cycle fetch/decode/execute sequencer for the
// accumulator datapath. Owns PC (14 bit), IR and AC, drives a 16Ki x 16
// registered-read memory and a combinational ALU, runs from address 0 to HALT.
//
// Ports:
//   clk, reset        single clock, synchronous active-high reset
//   start             begin execution (sampled only in IDLE)
//   mem_addr/wdata/we memory request ({2'b00, addr14}, data = AC, write enable)
//   mem_rdata         memory read data, valid one cycle after the address
//   alu_op/a/b        ALU request (a = AC), alu_result returned same cycle
//   pc, acc           architectural PC and AC
//   busy, halted      running / stopped at HALT or illegal opcode
//   error             illegal opcode executed, sticky until reset
module control_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    output logic        mem_we,
    input  logic [15:0] mem_rdata,
    output logic [3:0]  alu_op,
    output logic [15:0] alu_a,
    output logic [15:0] alu_b,
    input  logic [15:0] alu_result,
    output logic [15:0] pc,
    output logic [15:0] acc,
    output logic        busy,
    output logic        halted,
    output logic        error
);

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_LOAD_IR, S_DECODE,
        S_MEM_RD, S_EXEC, S_MEM_WR, S_HALTED
    } state_t;

    localparam logic [3:0] OP_HALT  = 4'h0;
    localparam logic [3:0] OP_LOAD  = 4'h1;
    localparam logic [3:0] OP_STORE = 4'h2;
    localparam logic [3:0] OP_SHL   = 4'h9;
    localparam logic [3:0] OP_SHR   = 4'hA;
    localparam logic [3:0] OP_JUMP  = 4'hB;
    localparam logic [3:0] OP_JZ    = 4'hC;
    localparam logic [3:0] OP_LOADI = 4'hD;
    localparam logic [3:0] OP_CLEAR = 4'hE;
    localparam logic [3:0] OP_ILL   = 4'hF;

    state_t      state_q, state_d;
    logic [13:0] pc_q, pc_d;
    logic [15:0] ir_q, ir_d;
    logic [15:0] ac_q, ac_d;
    logic        err_q, err_d;

    logic [3:0]  op;
    logic [11:0] fld;
    assign op  = ir_q[15:12];
    assign fld = ir_q[11:0];

    // Instruction opcode -> ALU opcode
    function automatic logic [3:0] alu_code(input logic [3:0] opc);
        case (opc)
            4'h3:    alu_code = 4'b0000;
            4'h4:    alu_code = 4'b0001;
            4'h5:    alu_code = 4'b0010;
            4'h6:    alu_code = 4'b1000;
            4'h7:    alu_code = 4'b1001;
            4'h8:    alu_code = 4'b1010;
            4'h9:    alu_code = 4'b0100;
            4'hA:    alu_code = 4'b0101;
            default: alu_code = 4'b0000;
        endcase
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            pc_q    <= '0;
            ir_q    <= '0;
            ac_q    <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            ac_q    <= ac_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        ac_d    = ac_q;
        err_d   = err_q;
        case (state_q)
            S_IDLE:    if (start) state_d = S_FETCH;
            S_FETCH:   state_d = S_LOAD_IR;
            S_LOAD_IR: begin
                ir_d    = mem_rdata;
                pc_d    = pc_q + 14'd1;   // 14-bit add wraps 0x3FFF -> 0
                state_d = S_DECODE;
            end
            S_DECODE: begin
                case (op)
                    OP_HALT:  state_d = S_HALTED;
                    OP_ILL: begin
                        state_d = S_HALTED;
                        err_d   = 1'b1;
                    end
                    OP_STORE: state_d = S_MEM_WR;
                    OP_SHL, OP_SHR: state_d = S_EXEC;
                    OP_JUMP: begin
                        pc_d    = {2'b00, fld};
                        state_d = S_FETCH;
                    end
                    OP_JZ: begin
                        if (ac_q == 16'd0) pc_d = {2'b00, fld};
                        state_d = S_FETCH;
                    end
                    OP_LOADI: begin
                        ac_d    = {4'h0, fld};
                        state_d = S_FETCH;
                    end
                    OP_CLEAR: begin
                        ac_d    = '0;
                        state_d = S_FETCH;
                    end
                    default:  state_d = S_MEM_RD;   // LOAD, ADD..XOR
                endcase
            end
            S_MEM_RD:  state_d = S_EXEC;
            S_EXEC: begin
                ac_d    = (op == OP_LOAD) ? mem_rdata : alu_result;
                state_d = S_FETCH;
            end
            S_MEM_WR:  state_d = S_FETCH;
            S_HALTED:  state_d = S_HALTED;
            default:   state_d = S_IDLE;
        endcase
    end

    // Moore outputs
    always_comb begin
        mem_addr = {2'b00, pc_q};
        alu_op   = 4'b0000;
        alu_b    = '0;
        if (state_q == S_MEM_RD || state_q == S_MEM_WR)
            mem_addr = {4'h0, fld};
        if (state_q == S_EXEC) begin
            alu_op = alu_code(op);
            alu_b  = (op == OP_SHL || op == OP_SHR) ? 16'd0 : mem_rdata;
        end
    end

    // Gated by reset so a reset edge landing in MEM_WR never writes memory.
    assign mem_we    = (state_q == S_MEM_WR) && !reset;
    assign mem_wdata = ac_q;
    assign alu_a     = ac_q;
    assign pc        = {2'b00, pc_q};
    assign acc       = ac_q;
    assign busy      = (state_q != S_IDLE) && (state_q != S_HALTED);
    assign halted    = (state_q == S_HALTED);
    assign error     = err_q;

endmodule

// File: doc/control_unit.md
# control_unit

Multi-cycle fetch/decode/execute sequencer for the accumulator datapath. It owns PC, IR and AC. It drives the shared `MainMemory` (16Ki x 16, registered read) and the combinational `ALU`, and runs a program from address 0 until HALT.

## Interface
Parameters: none (widths fixed: 16-bit data, 14-bit physical address, 12-bit instruction address field).

Ports:
- clk  in  1  single clock; all state changes on posedge
- reset  in  1  synchronous, active-high
- start  in  1  begin execution; sampled only in IDLE
- mem_addr  out  16  memory address = {2'b00, addr14}
- mem_wdata  out  16  write data (= AC)
- mem_we  out  1  memory write enable
- mem_rdata  in  16  memory `data_out`; valid the cycle after the address is presented with mem_we=0
- alu_op  out  4  ALU opcode
- alu_a  out  16  ALU operand1 (= AC)
- alu_b  out  16  ALU operand2
- alu_result  in  16  ALU result, same cycle
- pc  out  16  {2'b00, PC}
- acc  out  16  AC
- busy  out  1  state not IDLE/HALTED
- halted  out  1  state == HALTED
- error  out  1  illegal opcode executed; sticky until reset

## Operation
Instruction format:
- [15:12] op
- [11:0] field f
- operand address = {2'b00, f}

Opcodes:
- 0 HALT
- 1 LOAD: AC = M[f]
- 2 STORE: M[f] = AC
- 3 ADD (ALU 0000)
- 4 SUB (0001)
- 5 MUL (0010, low 16 bits)
- 6 AND (1000)
- 7 OR (1001)
- 8 XOR (1010)
- 9 SHL (0100)
- A SHR (0101)
- B JUMP: PC = f
- C JZ: PC = f if AC == 0
- D LOADI: AC = zero-extended f
- E CLEAR: AC = 0
- F illegal

States:
- IDLE: start=1 → FETCH.
- FETCH: mem_addr = PC, mem_we = 0 → LOAD_IR.
- LOAD_IR: IR ← mem_rdata; PC ← (PC + 1) mod 16384 → DECODE.
- DECODE, branching on IR[15:12]:
  - HALT → HALTED.
  - F → HALTED, error ← 1.
  - LOAD and ADD..XOR → MEM_RD.
  - STORE → MEM_WR.
  - SHL/SHR → EXEC.
  - JUMP/JZ/LOADI/CLEAR: perform the update in DECODE → FETCH.
- MEM_RD: mem_addr = operand address, mem_we = 0 → EXEC.
- EXEC:
  - alu_op from the opcode map above.
  - alu_b = mem_rdata for memory ops; 0 for shifts.
  - AC ← mem_rdata (LOAD) or alu_result (all others) → FETCH.
- MEM_WR: mem_addr = operand address, mem_wdata = AC, mem_we = 1 → FETCH.
- HALTED: absorbing; start ignored; only reset leaves.

Output rules:
- All outputs are Moore, decoded from state and registers.
- Outside FETCH/MEM_RD/MEM_WR: mem_addr = {2'b00, PC}.
- Outside EXEC: alu_op = 0000 and alu_b = 0.
- mem_we = (state == MEM_WR) && !reset, so a write is suppressed on a reset edge.

Reset values:
- state IDLE
- PC 0, IR 0, AC 0
- mem_we 0, mem_wdata 0
- busy 0, halted 0, error 0

Boundary rules:
- PC wraps 0x3FFF → 0x0000.
- Jump targets are limited to 0x000–0xFFF.
- JZ tests the AC value held in DECODE.
- Reset in any state, including mid-instruction, returns to IDLE next edge with all reset values. No memory write occurs on that edge.
- start is ignored outside IDLE.

## Timing
- The edge sampling start=1 in IDLE enters FETCH.
- Cycles per instruction:
  - LOAD/ADD..XOR: 5 (FETCH, LOAD_IR, DECODE, MEM_RD, EXEC)
  - STORE: 4
  - SHL/SHR: 4
  - JUMP/JZ/LOADI/CLEAR: 3
  - HALT/illegal: 3 to HALTED
- AC updates on the last edge of the instruction.
- The memory write lands on the edge ending MEM_WR.
- pc increments on the edge ending LOAD_IR.
- Read latency is 1 cycle: mem_rdata is used only in LOAD_IR and EXEC.

## Test plan
- **Idle hold:** reset, then start=0 for 10 cycles → pc=0, acc=0, busy=0, mem_we=0 throughout.
- **Basic program:**
  - Memory: M[0]=0x1010, M[1]=0x3011, M[2]=0x2012, M[3]=0x0000, M[0x10]=5, M[0x11]=7.
  - Pulse start → halted rises exactly 17 edges after start is sampled.
  - Final: M[0x12]=12, acc=12, pc=4, error=0.
- **Branch and ALU:**
  - Memory: M[0]=0xD0FF, M[1]=0x9000, M[2]=0xC007, M[3]=0xE000, M[4]=0xC007, M[7]=0x0000.
  - After SHL: acc=0x01FE.
  - JZ at 2 not taken; JZ at 4 taken.
  - Final: halted, pc=8, acc=0.
  - Also MUL 0x0100×0x0100 → acc=0x0000.
- **PC wrap:**
  - Memory: M[0]=0xC004, M[1]=0x0000, M[4..0x3FFF]=0xD001.
  - pc passes 0x3FFF → 0x0000.
  - Final: halted, pc=2, acc=1.
- **Illegal opcode:** M[0]=0xF123 → halted=1, error=1 after 3 edges. Further start pulses produce no change.
- **Reset mid-STORE:**
  - Memory: M[0]=0xD055, M[1]=0x2020, M[0x20]=0xAAAA.
  - Assert reset during the MEM_WR cycle → M[0x20] stays 0xAAAA; next cycle state IDLE and all outputs at reset values.
